// File: rtl/boot_load_ctrl.sv
// Boot loader: receives a length-prefixed byte image, writes it to instruction memory,
// verifies an additive checksum and releases the core only on a clean load.
module boot_load_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_LEN   = 4096,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        boot_wr_en,
    output logic [31:0] boot_wr_addr,
    output logic [7:0]  boot_wr_data,
    output logic        core_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] MaxLen     = 32'(MAX_LEN);
    localparam logic [31:0] TimeoutCnt = 32'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StChk,
        StDone,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] len_q;
    logic [31:0] idx_q;
    logic [31:0] timer_q;
    logic [7:0]  sum_q;

    logic        active;
    logic        accept;
    logic        timeout_hit;
    logic        last_len_byte;
    logic        last_data_byte;
    logic [31:0] len_next;
    logic [7:0]  chk_sum;

    assign active         = (state_q == StLen) || (state_q == StData) || (state_q == StChk);
    assign rx_ready       = busy;
    assign accept         = rx_valid && rx_ready;
    // Expires on the idle cycle that brings the counter up to TIMEOUT; an accepted byte wins.
    assign timeout_hit    = (timer_q + 32'd1) >= TimeoutCnt;
    assign last_len_byte  = (idx_q == 32'd3);
    assign last_data_byte = (idx_q == (len_q - 32'd1));
    // Length arrives little-endian, so each new byte shifts in at the top.
    assign len_next       = {rx_data, len_q[31:8]};
    assign chk_sum        = sum_q + rx_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) state_d = StLen;
            end
            StLen: begin
                if (accept) begin
                    if (last_len_byte) begin
                        if ((len_next == 32'd0) || (len_next > MaxLen)) state_d = StErr;
                        else                                          state_d = StData;
                    end
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end
            StData: begin
                if (accept) begin
                    if (last_data_byte) state_d = StChk;
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end
            StChk: begin
                if (accept) begin
                    if (chk_sum == 8'd0) state_d = StDone;
                    else                 state_d = StErr;
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            len_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            sum_q        <= '0;
            boot_wr_en   <= 1'b0;
            boot_wr_addr <= '0;
            boot_wr_data <= '0;
            core_hold    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_wr_en <= 1'b0;
            busy       <= (state_d == StLen) || (state_d == StData) || (state_d == StChk);
            done       <= (state_d == StDone);
            error      <= (state_d == StErr);
            core_hold  <= (state_d != StDone);

            if (!active) begin
                if (start) begin
                    len_q   <= '0;
                    idx_q   <= '0;
                    timer_q <= '0;
                    sum_q   <= '0;
                end
            end else if (accept) begin
                timer_q <= '0;
                case (state_q)
                    StLen: begin
                        len_q <= len_next;
                        idx_q <= last_len_byte ? 32'd0 : idx_q + 32'd1;
                    end
                    StData: begin
                        boot_wr_en   <= 1'b1;
                        boot_wr_addr <= BASE_ADDR + idx_q;
                        boot_wr_data <= rx_data;
                        sum_q        <= chk_sum;
                        idx_q        <= idx_q + 32'd1;
                    end
                    default: ;
                endcase
            end else begin
                timer_q <= timer_q + 32'd1;
            end
        end
    end

endmodule
